udp_framer_mc: RTL

UDP_FRAMER_MC -- requirements
Module: udp_framer_mc

---
 rtl/udp_framer_mc_if.sv | 13 +
 rtl/udp_framer_mc.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_framer_mc_if.sv
// Write-side bus from the UDP framer to the MAC: 32-bit frame words with
// SOF/EOF flags and a src/dst ready handshake.
interface udp_framer_mc_if;
   logic [31:0] wr_data_o;
   logic [3:0]  wr_flags_o;
   logic        wr_src_rdy_o;
   logic        wr_dst_rdy_i;

   modport master (output wr_data_o, output wr_flags_o, output wr_src_rdy_o,
                   input  wr_dst_rdy_i);
   modport slave  (input  wr_data_o, input  wr_flags_o, input  wr_src_rdy_o,
                   output wr_dst_rdy_i);
endinterface

// File: rtl/udp_framer_mc.sv
// Multi-channel UDP/IPv4/Ethernet framer: round-robin over pending channels,
// precomputes the IP header checksum, then streams header, sequence word and payload.
module udp_framer_mc #(
   parameter int          NUM_CH        = 4,
   parameter int          SIZE_W        = 9,
   parameter logic [47:0] SRC_MAC       = 48'h0037_ffff_3737,
   parameter logic [47:0] DST_MAC       = 48'h0090_f5de_6431,
   parameter logic [31:0] SRC_IP        = 32'ha9fe_4d01,
   parameter logic [31:0] DST_IP        = 32'ha9fe_a299,
   parameter logic [15:0] SRC_PORT_BASE = 16'h1234,
   parameter logic [15:0] DST_PORT      = 16'h1234
) (
   input  logic                     clk,
   input  logic                     reset,
   udp_framer_mc_if.master          wr,
   input  logic [NUM_CH-1:0]        ch_req_i,
   input  logic [NUM_CH*SIZE_W-1:0] ch_size_i,
   input  logic [NUM_CH*32-1:0]     ch_data_i,
   output logic [NUM_CH-1:0]        ch_rd_o,
   output logic                     busy_o,
   output logic [15:0]              pkt_count_o
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {IDLE, CSUM, HDR, SEQ, PAY} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [SIZE_W-1:0] pay_q, pay_d, size_q, size_d, pick_size;
   logic [NUM_CH-1:0] pend_q, pend_d, pick_mask;
   logic [CH_W-1:0]   ptr_q, ptr_d, gnt_q, gnt_d, pick;
   logic [15:0]       acc_q, acc_d;
   logic [15:0]       frm_q;
   logic [15:0]       seq_q [NUM_CH];
   logic              found, done, pay_last;
   logic [15:0]       ip_len, udp_len, src_port;

   function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   // IP header halfword i with the checksum field taken as zero
   function automatic logic [15:0] ip_hw(input logic [3:0] i, input logic [15:0] len,
                                         input logic [15:0] id);
      logic [15:0] h;
      case (i)
         4'd0:    h = 16'h4500;
         4'd1:    h = len;
         4'd2:    h = id;
         4'd4:    h = 16'h4011;
         4'd6:    h = SRC_IP[31:16];
         4'd7:    h = SRC_IP[15:0];
         4'd8:    h = DST_IP[31:16];
         4'd9:    h = DST_IP[15:0];
         default: h = 16'h0000;
      endcase
      return h;
   endfunction

   function automatic logic [31:0] hdr_word(input logic [3:0] i, input logic [15:0] csum,
                                            input logic [15:0] id, input logic [15:0] ilen,
                                            input logic [15:0] ulen, input logic [15:0] sport);
      logic [31:0] w;
      case (i)
         4'd0:    w = DST_MAC[47:16];
         4'd1:    w = {DST_MAC[15:0], SRC_MAC[47:32]};
         4'd2:    w = SRC_MAC[31:0];
         4'd3:    w = {16'h0800, 16'h4500};
         4'd4:    w = {ilen, id};
         4'd5:    w = {16'h0000, 16'h4011};
         4'd6:    w = {csum, SRC_IP[31:16]};
         4'd7:    w = {SRC_IP[15:0], DST_IP[31:16]};
         4'd8:    w = {DST_IP[15:0], sport};
         default: w = {DST_PORT, ulen};
      endcase
      return w;
   endfunction

   assign ip_len      = (16'(size_q) << 2) + 16'd30;
   assign udp_len     = (16'(size_q) << 2) + 16'd10;
   assign src_port    = SRC_PORT_BASE + 16'(gnt_q);
   assign pay_last    = (pay_q == size_q - 1'b1);
   assign pkt_count_o = frm_q;

   // Round-robin search starting at the channel after the last grant
   always_comb begin
      found     = 1'b0;
      pick      = '0;
      pick_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         int idx;
         idx = int'(ptr_q) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!found && pend_q[idx]) begin
            found = 1'b1;
            pick  = CH_W'(idx);
         end
      end
      pick_mask[pick] = found;
      pick_size       = ch_size_i[pick*SIZE_W +: SIZE_W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pay_q   <= '0;
         pend_q  <= '0;
         ptr_q   <= '0;
         frm_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) seq_q[c] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pay_q   <= pay_d;
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         // frm_q serves as both the completed-frame count and the IP identification
         if (done) begin
            frm_q        <= frm_q + 16'd1;
            seq_q[gnt_q] <= seq_q[gnt_q] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      gnt_q  <= gnt_d;
      size_q <= size_d;
      acc_q  <= acc_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pay_d   = pay_q;
      pend_d  = pend_q | ch_req_i;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      size_d  = size_q;
      acc_d   = acc_q;
      done    = 1'b0;
      case (state_q)
         IDLE: if (found) begin
            pend_d = (pend_q & ~pick_mask) | ch_req_i;
            ptr_d  = (int'(pick) == NUM_CH - 1) ? '0 : pick + 1'b1;
            gnt_d  = pick;
            size_d = pick_size;
            acc_d  = '0;
            cnt_d  = '0;
            if (pick_size != '0) state_d = CSUM;
         end
         CSUM: begin
            acc_d = oc_add(acc_q, ip_hw(cnt_q, ip_len, frm_q));
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               cnt_d   = '0;
               state_d = HDR;
            end
         end
         HDR: if (wr.wr_dst_rdy_i) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) state_d = SEQ;
         end
         SEQ: if (wr.wr_dst_rdy_i) begin
            pay_d   = '0;
            state_d = PAY;
         end
         PAY: if (wr.wr_dst_rdy_i) begin
            pay_d = pay_q + 1'b1;
            if (pay_last) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr.wr_data_o    = '0;
      wr.wr_flags_o   = '0;
      wr.wr_src_rdy_o = 1'b0;
      ch_rd_o         = '0;
      busy_o          = (state_q != IDLE);
      case (state_q)
         HDR: begin
            wr.wr_src_rdy_o  = 1'b1;
            wr.wr_data_o     = hdr_word(cnt_q, ~acc_q, frm_q, ip_len, udp_len, src_port);
            wr.wr_flags_o[0] = (cnt_q == 4'd0);
         end
         SEQ: begin
            wr.wr_src_rdy_o = 1'b1;
            wr.wr_data_o    = {16'h0000, seq_q[gnt_q]};
         end
         PAY: begin
            wr.wr_src_rdy_o  = 1'b1;
            wr.wr_data_o     = ch_data_i[gnt_q*32 +: 32];
            wr.wr_flags_o[1] = pay_last;
            ch_rd_o[gnt_q]   = wr.wr_dst_rdy_i;
         end
         default: ;
      endcase
   end
endmodule
